// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU memory stage and the audio DMA engine share
// one synchronous-read RAM port. The CPU wins by default. A DMA denied for
// MAX_WAIT cycles is forced a grant, and a DMA burst is capped at BURST_MAX
// beats. Read data is steered back to whichever master issued the read.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_last,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BEAT_LIMIT = BW'(BURST_MAX - 1);

  typedef enum logic {S_CPU, S_DMA} state_t;

  state_t        state;
  logic [WW-1:0] waitCnt;
  logic [BW-1:0] beatCnt;
  logic          rdPend;
  logic          rdDma;

  logic          dmaGnt;
  logic          rdReq;
  logic          burstEnd;

  // Grant decision; reset holds every grant low asynchronously.
  always_comb begin
    dmaGnt = 1'b0;
    if (reset) begin
      if (state == S_DMA) dmaGnt = dma_req;
      else                dmaGnt = dma_req & (~cpu_req | (waitCnt == WAIT_LIMIT));
    end
  end

  // Port mux toward the RAM; address/data follow the selected master even when idle.
  always_comb begin
    if (dmaGnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      rdReq     = ~dma_we;
    end else begin
      mem_we    = cpu_we & cpu_req & reset;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      rdReq     = cpu_req & ~cpu_we;
    end
    burstEnd = dma_last | (beatCnt == BEAT_LIMIT);
  end

  assign dma_gnt    = dmaGnt;
  assign owner      = dmaGnt;
  assign cpu_stall  = cpu_req & dmaGnt;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign cpu_rvalid = rdPend & ~rdDma;
  assign dma_rvalid = rdPend & rdDma;

  // Burst FSM, DMA starvation counter and read-return tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_CPU;
      waitCnt <= '0;
      beatCnt <= '0;
      rdPend  <= 1'b0;
      rdDma   <= 1'b0;
    end else begin
      if (dmaGnt)
        waitCnt <= '0;
      else if (dma_req)
        waitCnt <= (waitCnt == WAIT_LIMIT) ? waitCnt : waitCnt + 1'b1;
      else
        waitCnt <= '0;

      // An ungranted cycle is either idle in S_CPU or an abandoned burst;
      // both leave the port with the CPU and a cleared beat count.
      if (dmaGnt && !burstEnd) begin
        state   <= S_DMA;
        beatCnt <= beatCnt + 1'b1;
      end else begin
        state   <= S_CPU;
        beatCnt <= '0;
      end

      rdPend <= rdReq;
      if (rdReq) rdDma <= dmaGnt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-return scoreboard and a small
// synchronous RAM model behind the memory port.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 8;
  localparam int BURST_MAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_we, owner;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read, write on the clock edge; preloaded in reset.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (!reset) begin
      ram[10'h004] <= 32'hCAFE0001;
      ram[10'h008] <= 32'hD0A00020;
      ram[10'h00C] <= 32'hC0C00030;
    end else if (mem_we) begin
      ram[mem_addr[11:2]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[11:2]];
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] cpuQ[$];
  logic [31:0] dmaQ[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset) begin
        if (cpu_rvalid && dma_rvalid) chk("rvalid_both", 32'(cpu_rvalid & dma_rvalid), 0);
        if (cpu_rvalid) begin
          if (cpuQ.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 0);
          else chk("cpu_rdata", cpu_rdata, cpuQ.pop_front());
        end
        if (dma_rvalid) begin
          if (dmaQ.size() == 0) chk("dma_rvalid_unexpected", 32'(dma_rvalid), 0);
          else chk("dma_rdata", dma_rdata, dmaQ.pop_front());
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuDrv(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic dmaDrv(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic last);
    dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd; dma_last = last;
  endtask

  task automatic chkGrant(input string tag, input logic expGnt, input logic expStall);
    chk({tag, "_gnt"}, 32'(dma_gnt), 32'(expGnt));
    chk({tag, "_owner"}, 32'(owner), 32'(expGnt));
    chk({tag, "_stall"}, 32'(cpu_stall), 32'(expStall));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cpuDrv(0, 0, 0, 0);
    dmaDrv(0, 0, 0, 0, 0);
    fork monitor(); join_none

    // Reset forces every grant and strobe low even with both masters requesting.
    #2;
    cpuDrv(1, 1, 32'h40, 32'h1);
    dmaDrv(1, 1, 32'h80, 32'h2, 0);
    #1;
    chkGrant("rst", 0, 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
    cpuDrv(0, 0, 0, 0);
    dmaDrv(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();

    // CPU-only read.
    cpuDrv(1, 0, 32'h10, 0);
    #1;
    chkGrant("cpurd", 0, 0);
    chk("cpurd_addr", mem_addr, 32'h10);
    chk("cpurd_we", 32'(mem_we), 0);
    cpuQ.push_back(32'hCAFE0001);
    step();
    cpuDrv(0, 0, 32'h10, 0);
    chk("cpurd_rvalid", 32'(cpu_rvalid), 1);
    chk("cpurd_dma_rvalid", 32'(dma_rvalid), 0);

    // CPU write then read back.
    cpuDrv(1, 1, 32'h40, 32'h11112222);
    #1;
    chk("cpuwr_we", 32'(mem_we), 1);
    chk("cpuwr_addr", mem_addr, 32'h40);
    chk("cpuwr_wdata", mem_wdata, 32'h11112222);
    step();
    cpuDrv(1, 0, 32'h40, 0);
    cpuQ.push_back(32'h11112222);
    step();
    cpuDrv(0, 0, 0, 0);
    step();

    // Contention: CPU wins for MAX_WAIT cycles, then DMA is forced a grant.
    cpuDrv(1, 0, 32'h10, 0);
    dmaDrv(1, 0, 32'h20, 0, 1);
    for (int i = 0; i < 8; i++) begin
      #1;
      chkGrant($sformatf("cont%0d", i), 0, 0);
      cpuQ.push_back(32'hCAFE0001);
      step();
    end
    #1;
    chkGrant("cont8", 1, 1);
    chk("cont8_addr", mem_addr, 32'h20);
    dmaQ.push_back(32'hD0A00020);
    step();
    #1;
    chkGrant("cont9", 0, 0);
    cpuQ.push_back(32'hCAFE0001);
    step();
    cpuDrv(0, 0, 0, 0);
    dmaDrv(0, 0, 0, 0, 0);
    step();

    // Burst cap: 4 beats back-to-back, CPU gets cycle 5, beats 5-6 follow.
    for (int b = 1; b <= 4; b++) begin
      dmaDrv(1, 1, 32'h100 + 32'(4 * (b - 1)), 32'hB0000000 + 32'(b), 0);
      if (b == 4) cpuDrv(1, 0, 32'h10, 0);
      #1;
      chkGrant($sformatf("burst%0d", b), 1, (b == 4));
      chk($sformatf("burst%0d_we", b), 32'(mem_we), 1);
      chk($sformatf("burst%0d_addr", b), mem_addr, 32'h100 + 32'(4 * (b - 1)));
      step();
    end
    dmaDrv(1, 1, 32'h110, 32'hB0000005, 0);
    #1;
    chkGrant("burst5cpu", 0, 0);
    chk("burst5cpu_addr", mem_addr, 32'h10);
    chk("burst5cpu_we", 32'(mem_we), 0);
    cpuQ.push_back(32'hCAFE0001);
    step();
    cpuDrv(0, 0, 0, 0);
    #1;
    chkGrant("burst5", 1, 0);
    chk("burst5_addr", mem_addr, 32'h110);
    step();
    dmaDrv(1, 1, 32'h114, 32'hB0000006, 1);
    #1;
    chkGrant("burst6", 1, 0);
    step();
    dmaDrv(0, 0, 0, 0, 0);
    cpuDrv(1, 0, 32'h100, 0);
    cpuQ.push_back(32'hB0000001);
    step();
    cpuDrv(1, 0, 32'h114, 0);
    cpuQ.push_back(32'hB0000006);
    step();
    cpuDrv(0, 0, 0, 0);
    step();

    // Interleaved reads: DMA then CPU, returns in order and never together.
    dmaDrv(1, 0, 32'h20, 0, 1);
    #1;
    chkGrant("ilv_dma", 1, 0);
    dmaQ.push_back(32'hD0A00020);
    step();
    dmaDrv(0, 0, 0, 0, 0);
    cpuDrv(1, 0, 32'h30, 0);
    chk("ilv_dma_rvalid", 32'(dma_rvalid), 1);
    chk("ilv_cpu_rvalid0", 32'(cpu_rvalid), 0);
    cpuQ.push_back(32'hC0C00030);
    step();
    cpuDrv(0, 0, 0, 0);
    chk("ilv_cpu_rvalid1", 32'(cpu_rvalid), 1);
    chk("ilv_dma_rvalid1", 32'(dma_rvalid), 0);
    step();

    // Abandoned burst: DMA drops mid-burst, CPU served at once, state back to S_CPU.
    dmaDrv(1, 1, 32'h200, 32'h5A5A5A5A, 0);
    #1;
    chkGrant("abd_beat", 1, 0);
    step();
    dmaDrv(0, 0, 0, 0, 0);
    cpuDrv(1, 0, 32'h10, 0);
    #1;
    chkGrant("abd_cpu", 0, 0);
    chk("abd_cpu_addr", mem_addr, 32'h10);
    cpuQ.push_back(32'hCAFE0001);
    step();
    dmaDrv(1, 0, 32'h20, 0, 1);
    #1;
    chkGrant("abd_state", 0, 0);
    cpuQ.push_back(32'hCAFE0001);
    step();
    cpuDrv(0, 0, 0, 0);
    #1;
    chkGrant("abd_dma", 1, 0);
    dmaQ.push_back(32'hD0A00020);
    step();
    dmaDrv(0, 0, 0, 0, 0);
    step();

    // Asynchronous reset during beat 2 discards the burst and the pending read.
    dmaDrv(1, 0, 32'h20, 0, 0);
    #1;
    chkGrant("rb_beat1", 1, 0);
    step();
    dmaDrv(1, 1, 32'h300, 32'h33333333, 0);
    #1;
    chkGrant("rb_beat2", 1, 0);
    chk("rb_pend_rvalid", 32'(dma_rvalid), 1);
    chk("rb_pend_rdata", dma_rdata, 32'hD0A00020);
    #1 reset = 1'b0;
    #1;
    chkGrant("rb_async", 0, 0);
    chk("rb_async_we", 32'(mem_we), 0);
    chk("rb_async_dma_rvalid", 32'(dma_rvalid), 0);
    chk("rb_async_cpu_rvalid", 32'(cpu_rvalid), 0);
    dmaDrv(1, 1, 32'h300, 32'h33333333, 0);
    cpuDrv(1, 0, 32'h10, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chkGrant("rb_release", 0, 0);
    chk("rb_release_addr", mem_addr, 32'h10);
    cpuQ.push_back(32'hCAFE0001);
    step();
    cpuDrv(0, 0, 0, 0);
    for (int b = 1; b <= 4; b++) begin
      dmaDrv(1, 1, 32'h300 + 32'(4 * (b - 1)), 32'h30000000 + 32'(b), 0);
      if (b == 4) cpuDrv(1, 0, 32'h10, 0);
      #1;
      chkGrant($sformatf("rb_burst%0d", b), 1, (b == 4));
      step();
    end
    #1;
    chkGrant("rb_burst_end", 0, 0);
    cpuQ.push_back(32'hCAFE0001);
    step();
    cpuDrv(0, 0, 0, 0);
    dmaDrv(0, 0, 0, 0, 0);
    repeat (3) step();

    chk("cpuQ_drained", 32'(cpuQ.size()), 0);
    chk("dmaQ_drained", 32'(dmaQ.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
